// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_if
// Purpose  : Instruction-memory request bus and fetch-to-decode handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_gnt;
   logic             imem_rvalid;
   logic [WIDTH-1:0] imem_rdata;
   logic             if_valid;
   logic [WIDTH-1:0] if_instr;
   logic [WIDTH-1:0] if_pc;
   logic             if_ready;

   // master = fetch unit; slave = instruction memory plus decode stage
   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc,
      output imem_gnt, imem_rvalid, imem_rdata, if_ready
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : RV32I program counter and single-outstanding instruction fetch.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  wire logic             clk,
   input  wire logic             rstN,
   output logic      [WIDTH-1:0] pc,
   input  wire logic [WIDTH-1:0] pc_plus4,
   input  wire logic             redirect_valid,
   input  wire logic [WIDTH-1:0] redirect_target,
   output logic                  misalign,
   pc_fetch_unit_if.master       bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pc;
   logic             r_imem_req;
   logic             r_if_valid;
   logic [WIDTH-1:0] r_if_instr;
   logic [WIDTH-1:0] r_if_pc;
   logic             r_misalign;
   logic             r_kill;

   logic             w_redir_ok;
   logic             w_redir_bad;

   assign w_redir_ok  = redirect_valid & (redirect_target[1:0] == 2'b00);
   assign w_redir_bad = redirect_valid & (redirect_target[1:0] != 2'b00);

   assign pc            = r_pc;
   assign misalign      = r_misalign;
   assign bus.imem_req  = r_imem_req;
   assign bus.imem_addr = r_pc;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_instr  = r_if_instr;
   assign bus.if_pc     = r_if_pc;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_imem_req <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_instr <= '0;
         r_if_pc    <= '0;
         r_misalign <= 1'b0;
         r_kill     <= 1'b0;
      end else begin
         if (w_redir_bad) begin
            r_misalign <= 1'b1;
         end

         if (w_redir_ok) begin
            r_pc       <= redirect_target;
            r_if_valid <= 1'b0;
            case (r_state)
               S_REQ: begin
                  // A granted request still owes a response that must be dropped
                  if (bus.imem_gnt) begin
                     r_kill     <= 1'b1;
                     r_imem_req <= 1'b0;
                     r_state    <= S_WAIT;
                  end else begin
                     r_imem_req <= 1'b1;
                  end
               end
               S_WAIT: begin
                  if (bus.imem_rvalid) begin
                     r_kill     <= 1'b0;
                     r_imem_req <= 1'b1;
                     r_state    <= S_REQ;
                  end else begin
                     r_kill     <= 1'b1;
                  end
               end
               default: begin
                  r_imem_req <= 1'b1;
                  r_state    <= S_REQ;
               end
            endcase
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_imem_req <= 1'b1;
                  r_state    <= S_REQ;
               end
               S_REQ: begin
                  if (bus.imem_gnt) begin
                     r_imem_req <= 1'b0;
                     r_state    <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (bus.imem_rvalid) begin
                     if (r_kill) begin
                        r_kill     <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= S_REQ;
                     end else begin
                        r_if_instr <= bus.imem_rdata;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_state    <= S_HOLD;
                     end
                  end
               end
               S_HOLD: begin
                  if (bus.if_ready) begin
                     r_if_valid <= 1'b0;
                     r_pc       <= pc_plus4;
                     r_imem_req <= 1'b1;
                     r_state    <= S_REQ;
                  end
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Randomized bench for pc_fetch_unit against a program-order model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        misalign;

   pc_fetch_unit_if #(.WIDTH(32)) bus ();

   pc_fetch_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rstN            (rstN),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .misalign        (misalign),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   // Adder_PC stand-in
   assign pc_plus4 = pc + 32'd4;

   int          n_checks = 0;
   int          n_fail   = 0;

   // Program-order model: next instruction address, sticky misalign flag
   logic [31:0] exp_pc;
   bit          exp_mis;
   bit          after_redir;
   logic [31:0] acc_q[$];
   int          idle_cnt;

   // Memory model: at most one transaction, fixed content per address
   bit          out_busy;
   logic [31:0] out_addr;
   int          out_cnt;

   int          k_gnt, k_ready, k_redir, k_lat_min, k_lat_max;
   int          ovr_mode;
   logic [31:0] ovr_tgt;
   logic [31:0] stall_pc;
   int          stall_left;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      if ($urandom_range(3) == 0) t = 32'hFFFF_FF00 | ($urandom_range(63) << 2);
      else                        t = $urandom_range(4095) << 2;
      if ($urandom_range(4) == 0) t[1:0] = 2'($urandom_range(3, 1));
      return t;
   endfunction

   task automatic step();
      bit          rv, g, rd, rdy, al;
      logic [31:0] tgt;
      @(negedge clk);
      check("pc", pc, exp_pc);
      check("misalign", 32'(misalign), 32'(exp_mis));
      if (bus.imem_req) check("imem_addr", bus.imem_addr, exp_pc);
      if (bus.if_valid) begin
         check("if_pc", bus.if_pc, exp_pc);
         check("if_instr", bus.if_instr, mem_word(exp_pc));
      end
      if (after_redir) check("valid_after_redirect", 32'(bus.if_valid), 32'd0);
      if (out_busy)    check("req_while_outstanding", 32'(bus.imem_req), 32'd0);

      rv  = out_busy && (out_cnt == 0);
      g   = bus.imem_req && !out_busy && ($urandom_range(99) < k_gnt);
      rdy = $urandom_range(99) < k_ready;
      if (stall_left > 0 && bus.if_valid && bus.if_pc == stall_pc) begin
         rdy = 1'b0;
         stall_left--;
         check("stall_no_req", 32'(bus.imem_req), 32'd0);
      end
      rd  = $urandom_range(99) < k_redir;
      tgt = rand_target();
      if (ovr_mode == 1 || (ovr_mode == 2 && out_busy && out_cnt != 0)) begin
         rd       = 1'b1;
         tgt      = ovr_tgt;
         ovr_mode = 0;
      end

      bus.imem_gnt    = g;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? mem_word(out_addr) : $urandom();
      bus.if_ready    = rdy;
      redirect_valid  = rd;
      redirect_target = tgt;

      al = rd && (tgt[1:0] == 2'b00);
      if (rd && !al) exp_mis = 1'b1;
      idle_cnt++;
      if (al) begin
         exp_pc   = tgt;
         idle_cnt = 0;
      end else if (bus.if_valid && rdy) begin
         acc_q.push_back(bus.if_pc);
         exp_pc   = exp_pc + 32'd4;
         idle_cnt = 0;
      end
      after_redir = al;

      if (rv)            out_busy = 1'b0;
      else if (out_busy) out_cnt--;
      if (g) begin
         out_busy = 1'b1;
         out_addr = bus.imem_addr;
         out_cnt  = int'($urandom_range(k_lat_max, k_lat_min)) - 1;
      end
      if (idle_cnt > 60) begin
         check("progress_timeout", 32'(idle_cnt), 32'd0);
         idle_cnt = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstN            = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.if_ready    = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      #1;
      check("rst_pc", pc, RESET_PC);
      check("rst_imem_req", 32'(bus.imem_req), 32'd0);
      check("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check("rst_if_instr", bus.if_instr, 32'd0);
      check("rst_if_pc", bus.if_pc, 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      exp_pc      = RESET_PC;
      exp_mis     = 1'b0;
      after_redir = 1'b0;
      out_busy    = 1'b0;
      out_cnt     = 0;
      idle_cnt    = 0;
      stall_left  = 0;
      ovr_mode    = 0;
      acc_q.delete();
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      #1 check("idle_no_req", 32'(bus.imem_req), 32'd0);
      @(posedge clk);
      #1 check("idle_to_req", 32'(bus.imem_req), 32'd1);
   endtask

   task automatic wait_acc(input int n, input string tag);
      for (int i = 0; i < 200 && acc_q.size() < n; i++) step();
      check(tag, 32'(acc_q.size() >= n), 32'd1);
   endtask

   initial begin
      rstN            = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.if_ready    = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      stall_pc        = '0;
      ovr_tgt         = '0;

      // Straight-line fetch, 1-cycle memory, decode always ready
      k_gnt = 100; k_ready = 100; k_redir = 0; k_lat_min = 1; k_lat_max = 1;
      do_reset();
      wait_acc(4, "t1_timeout");
      for (int i = 0; i < 4; i++) check("t1_seq", acc_q[i], 32'(i * 4));

      // Decode holds off for 5 cycles at pc 8
      do_reset();
      stall_pc   = 32'h8;
      stall_left = 5;
      wait_acc(4, "t2_timeout");
      check("t2_stall_cycles", 32'(stall_left), 32'd0);
      check("t2_seq8", acc_q[2], 32'h8);
      check("t2_seq12", acc_q[3], 32'hC);

      // Redirect while a response is pending
      k_lat_min = 2; k_lat_max = 2;
      do_reset();
      ovr_tgt  = 32'h40;
      ovr_mode = 2;
      wait_acc(2, "t3_timeout");
      check("t3_fired", 32'(ovr_mode), 32'd0);
      check("t3_first", acc_q[0], 32'h40);
      check("t3_second", acc_q[1], 32'h44);

      // Misaligned redirect is ignored apart from the sticky flag
      k_lat_min = 1; k_lat_max = 1;
      ovr_tgt  = 32'h43;
      ovr_mode = 1;
      repeat (20) step();
      check("t4_misalign", 32'(misalign), 32'd1);
      for (int i = 1; i < acc_q.size(); i++) check("t4_stream", acc_q[i], acc_q[i-1] + 32'd4);

      // Grant withheld, then redirect during the request phase
      k_gnt = 0;
      do_reset();
      repeat (3) step();
      ovr_tgt  = 32'h80;
      ovr_mode = 1;
      step();
      @(posedge clk);
      #1;
      check("t5_addr", bus.imem_addr, 32'h80);
      check("t5_req", 32'(bus.imem_req), 32'd1);
      k_gnt = 100;
      wait_acc(1, "t5_timeout");
      check("t5_first", acc_q[0], 32'h80);

      // Reset pulse while waiting for the memory
      k_lat_min = 3; k_lat_max = 3;
      for (int i = 0; i < 20 && !out_busy; i++) step();
      check("t6_in_wait", 32'(out_busy), 32'd1);
      do_reset();
      wait_acc(1, "t6_timeout");
      check("t6_restart", acc_q[0], RESET_PC);

      // Random traffic with redirects, backpressure and variable latency
      k_gnt = 60; k_ready = 70; k_redir = 8; k_lat_min = 1; k_lat_max = 3;
      repeat (1500) step();
      do_reset();
      repeat (1500) step();
      check("rand_accepts", 32'(acc_q.size() > 50), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
